// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped line cache with burst refill; `define ICACHE_STATS_EN adds hit/miss counters
module icache_direct_mapped #(
  parameter int ADDR_WID   = 64,
  parameter int INSTR_WID  = 32,
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [ADDR_WID-1:0]  addr_i,
  input  logic                 flush_i,
  output logic [INSTR_WID-1:0] instr_o,
  output logic                 instr_valid_o,
  output logic                 busy_o,
  output logic                 mem_req_o,
  output logic [ADDR_WID-1:0]  mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [INSTR_WID-1:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);
  localparam int BO = $clog2(INSTR_WID/8);
  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WID - BO - WO - IW;
  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;
  state_t state, nxt;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [INSTR_WID-1:0] data [NUM_LINES*LINE_WORDS];
  logic [TW-1:0] a_tag, l_tag;
  logic [IW-1:0] a_idx, l_idx;
  logic [WO-1:0] a_off, l_off, cnt;
  logic lookup, hit, last, flush_pend, unused;
  assign a_off  = addr_i[BO +: WO];
  assign a_idx  = addr_i[BO+WO +: IW];
  assign a_tag  = addr_i[ADDR_WID-1 -: TW];
  assign unused = ^addr_i;
  assign lookup = state == IDLE && req_valid_i;
  assign hit    = valid[a_idx] && tags[a_idx] == a_tag && !flush_i;
  assign last   = state == FILL && mem_rvalid_i && cnt == WO'(LINE_WORDS-1);
  always_comb begin
    nxt        = state;
    busy_o     = state == REQ || state == FILL;
    mem_req_o  = state == REQ;
    mem_addr_o = mem_req_o ? {l_tag, l_idx, {(WO+BO){1'b0}}} : '0;
    case (state)
      IDLE: nxt = lookup && !hit ? REQ : IDLE;
      REQ:  nxt = mem_gnt_i ? FILL : REQ;
      FILL: nxt = last ? RESP : FILL;
      RESP: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      valid         <= '0;
      cnt           <= '0;
      flush_pend    <= 1'b0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
    end else begin
      state         <= nxt;
      instr_valid_o <= 1'b0;
      if (lookup && hit) begin
        instr_o       <= data[{a_idx, a_off}];
        instr_valid_o <= 1'b1;
      end
      if (state == IDLE && flush_i) valid <= '0;
      if (state != IDLE && flush_i) flush_pend <= 1'b1;
      if (state == REQ && mem_gnt_i) cnt <= '0;
      if (state == FILL && mem_rvalid_i) cnt <= cnt + WO'(1);
      if (last) begin
        valid[l_idx]  <= 1'b1;
        instr_o       <= l_off == cnt ? mem_rdata_i : data[{l_idx, l_off}];
        instr_valid_o <= 1'b1;
      end
      // deferred flush lands as the refill hands back to IDLE
      if (state == RESP && (flush_pend || flush_i)) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (lookup && !hit) {l_tag, l_idx, l_off} <= {a_tag, a_idx, a_off};
    if (state == FILL && mem_rvalid_i) data[{l_idx, cnt}] <= mem_rdata_i;
    if (last) tags[l_idx] <= l_tag;
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (lookup) begin
      if (hit && hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
      if (!hit && miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif
endmodule
